csm_shared_mem: RTL and testbench

// - Responder side of the CSM two-processor protocol: the shared register file that processors A and B drive.
// - Serves read, write, hold and release per port; tracks per-address hold ownership; arbitrates conflicting same-cycle requests.
// - Flags illegal accesses with a one-cycle error pulse.

---
 rtl/csm_shared_mem.sv | 158 +++++++++++++++
 tb/tb_csm_shared_mem.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csm_shared_mem.sv
// csm_shared_mem: two-port shared register file with per-address hold ownership and round-robin conflict arbitration.
// Optional auto-release of holds after HOLD_TIMEOUT cycles when CSM_HOLD_TIMEOUT_EN is defined (adds hold_expired).
module csm_shared_mem #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 2,
    parameter int HOLD_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     a_valid,
    input  logic [1:0]               a_op,
    input  logic [ADDR_W-1:0]        a_addr,
    input  logic [DATA_W-1:0]        a_wdata,
    output logic                     a_ready,
    output logic                     a_done,
    output logic [DATA_W-1:0]        a_rdata,
    output logic                     a_err,
    input  logic                     b_valid,
    input  logic [1:0]               b_op,
    input  logic [ADDR_W-1:0]        b_addr,
    input  logic [DATA_W-1:0]        b_wdata,
    output logic                     b_ready,
    output logic                     b_done,
    output logic [DATA_W-1:0]        b_rdata,
    output logic                     b_err,
    output logic [(1<<ADDR_W)-1:0]   held,
    output logic [(1<<ADDR_W)-1:0]   owner_b
`ifdef CSM_HOLD_TIMEOUT_EN
    ,
    output logic [(1<<ADDR_W)-1:0]   hold_expired
`endif
);
    localparam int N = 1 << ADDR_W;
    localparam logic [1:0] OP_RD = 2'b00, OP_WR = 2'b01, OP_HD = 2'b10, OP_RL = 2'b11;

    logic [DATA_W-1:0] r_mem [N];
    logic [DATA_W-1:0] w_mem_n [N];
    logic [N-1:0]      r_held, r_owner_b, w_held_n, w_owner_n;
    logic              r_prio_b;
    logic              r_a_done, r_a_err, r_b_done, r_b_err;
    logic [DATA_W-1:0] r_a_rdata, r_b_rdata;
    logic              w_conf, w_a_go, w_b_go, w_a_err, w_b_err;

    // Only a pair of reads may share an address in one cycle; anything else is arbitrated.
    assign w_conf  = a_valid && b_valid && (a_addr == b_addr) && (a_op != OP_RD || b_op != OP_RD);
    assign a_ready = !w_conf || !r_prio_b;
    assign b_ready = !w_conf || r_prio_b;
    assign w_a_go  = a_valid && a_ready;
    assign w_b_go  = b_valid && b_ready;

    assign w_a_err = (a_op == OP_RL) ? !(r_held[a_addr] && !r_owner_b[a_addr])
                                     : (r_held[a_addr] && r_owner_b[a_addr]);
    assign w_b_err = (b_op == OP_RL) ? !(r_held[b_addr] && r_owner_b[b_addr])
                                     : (r_held[b_addr] && !r_owner_b[b_addr]);

`ifdef CSM_HOLD_TIMEOUT_EN
    localparam int CW = $clog2(HOLD_TIMEOUT + 1);
    logic [CW-1:0] r_cnt [N];
    logic [CW-1:0] w_cnt_n [N];
    logic [N-1:0]  r_exp, w_exp_n;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (HOLD_TIMEOUT != 0);
`endif

    always_comb begin
        w_mem_n   = r_mem;
        w_held_n  = r_held;
        w_owner_n = r_owner_b;
`ifdef CSM_HOLD_TIMEOUT_EN
        w_cnt_n = r_cnt;
        w_exp_n = '0;
        for (int i = 0; i < N; i++) begin
            if (r_held[i]) begin
                w_cnt_n[i] = r_cnt[i] - CW'(1);
                if (r_cnt[i] == CW'(1)) begin
                    w_held_n[i] = 1'b0;
                    w_exp_n[i]  = 1'b1;
                end
            end
        end
`endif
        // Ops are applied after expiry so an owner's release or re-hold wins over a same-cycle timeout.
        if (w_a_go && !w_a_err) begin
            if (a_op == OP_WR) w_mem_n[a_addr] = a_wdata;
            if (a_op == OP_HD) begin
                w_held_n[a_addr]  = 1'b1;
                w_owner_n[a_addr] = 1'b0;
            end
            if (a_op == OP_RL) w_held_n[a_addr] = 1'b0;
`ifdef CSM_HOLD_TIMEOUT_EN
            if (a_op == OP_HD) w_cnt_n[a_addr] = CW'(HOLD_TIMEOUT);
            if (a_op == OP_HD || a_op == OP_RL) w_exp_n[a_addr] = 1'b0;
`endif
        end
        if (w_b_go && !w_b_err) begin
            if (b_op == OP_WR) w_mem_n[b_addr] = b_wdata;
            if (b_op == OP_HD) begin
                w_held_n[b_addr]  = 1'b1;
                w_owner_n[b_addr] = 1'b1;
            end
            if (b_op == OP_RL) w_held_n[b_addr] = 1'b0;
`ifdef CSM_HOLD_TIMEOUT_EN
            if (b_op == OP_HD) w_cnt_n[b_addr] = CW'(HOLD_TIMEOUT);
            if (b_op == OP_HD || b_op == OP_RL) w_exp_n[b_addr] = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem     <= '{default: '0};
            r_held    <= '0;
            r_owner_b <= '0;
            r_prio_b  <= 1'b0;
            r_a_done  <= 1'b0;
            r_a_err   <= 1'b0;
            r_a_rdata <= '0;
            r_b_done  <= 1'b0;
            r_b_err   <= 1'b0;
            r_b_rdata <= '0;
        end else begin
            r_mem     <= w_mem_n;
            r_held    <= w_held_n;
            r_owner_b <= w_owner_n;
            r_prio_b  <= w_conf ? !r_prio_b : r_prio_b;
            r_a_done  <= w_a_go;
            r_a_err   <= w_a_go && w_a_err;
            r_a_rdata <= (w_a_go && a_op == OP_RD && !w_a_err) ? r_mem[a_addr] : '0;
            r_b_done  <= w_b_go;
            r_b_err   <= w_b_go && w_b_err;
            r_b_rdata <= (w_b_go && b_op == OP_RD && !w_b_err) ? r_mem[b_addr] : '0;
        end
    end

`ifdef CSM_HOLD_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '{default: '0};
            r_exp <= '0;
        end else begin
            r_cnt <= w_cnt_n;
            r_exp <= w_exp_n;
        end
    end

    assign hold_expired = r_exp;
`endif

    assign a_done  = r_a_done;
    assign a_err   = r_a_err;
    assign a_rdata = r_a_rdata;
    assign b_done  = r_b_done;
    assign b_err   = r_b_err;
    assign b_rdata = r_b_rdata;
    assign held    = r_held;
    assign owner_b = r_owner_b;
endmodule

// File: tb/tb_csm_shared_mem.sv
// tb_csm_shared_mem: directed self-checking bench for csm_shared_mem (timeout section active with CSM_HOLD_TIMEOUT_EN).
module tb_csm_shared_mem;
    localparam int DW = 8, AW = 2, N = 4;
    localparam logic [1:0] RD = 2'b00, WR = 2'b01, HD = 2'b10, RL = 2'b11;

    logic          clk = 1'b0, reset = 1'b1;
    logic          a_valid = 1'b0, b_valid = 1'b0;
    logic [1:0]    a_op = '0, b_op = '0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_ready, a_done, a_err, b_ready, b_done, b_err;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [N-1:0]  held, owner_b;
`ifdef CSM_HOLD_TIMEOUT_EN
    logic [N-1:0]  hold_expired;
`endif
    int n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    csm_shared_mem #(.DATA_W(DW), .ADDR_W(AW), .HOLD_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_op(a_op), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_done(a_done), .a_rdata(a_rdata), .a_err(a_err),
        .b_valid(b_valid), .b_op(b_op), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_done(b_done), .b_rdata(b_rdata), .b_err(b_err),
        .held(held), .owner_b(owner_b)
`ifdef CSM_HOLD_TIMEOUT_EN
        , .hold_expired(hold_expired)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic v, input logic [1:0] op, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        a_valid = v; a_op = op; a_addr = ad; a_wdata = wd;
    endtask

    task automatic drv_b(input logic v, input logic [1:0] op, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        b_valid = v; b_op = op; b_addr = ad; b_wdata = wd;
    endtask

    initial begin
        step; step;
        chk("rst_held", held, 0);
        chk("rst_owner", owner_b, 0);
        chk("rst_a_done", a_done, 0);
        chk("rst_b_done", b_done, 0);
        chk("rst_a_err", a_err, 0);
        chk("rst_a_rdata", a_rdata, 0);
        reset = 1'b0;

        // write then read back on port A
        drv_a(1, WR, 1, 8'hA5); #1;
        chk("t1_a_ready", a_ready, 1);
        step;
        chk("t1_wr_done", a_done, 1);
        chk("t1_wr_err", a_err, 0);
        drv_a(1, RD, 1, 0);
        step;
        chk("t1_rd_done", a_done, 1);
        chk("t1_rd_data", a_rdata, 8'hA5);
        chk("t1_rd_err", a_err, 0);
        drv_a(0, RD, 0, 0);
        step;
        chk("t1_idle_done", a_done, 0);

        // hold vs read conflict, A has priority
        drv_a(1, HD, 2, 0); drv_b(1, RD, 2, 0); #1;
        chk("t2_a_ready", a_ready, 1);
        chk("t2_b_ready", b_ready, 0);
        step;
        chk("t2_a_done", a_done, 1);
        chk("t2_a_err", a_err, 0);
        chk("t2_b_done_stall", b_done, 0);
        chk("t2_held2", held[2], 1);
        chk("t2_owner2", owner_b[2], 0);
        drv_a(0, RD, 0, 0); #1;
        chk("t2_b_ready_retry", b_ready, 1);
        step;
        chk("t2_b_done", b_done, 1);
        chk("t2_b_err", b_err, 1);
        chk("t2_b_rdata", b_rdata, 0);
        drv_b(0, RD, 0, 0);

        // hold / release / read by other port
        drv_a(1, HD, 0, 0);
        step;
        chk("t3_hold_err", a_err, 0);
        chk("t3_held0", held[0], 1);
        drv_a(1, RL, 0, 0);
        step;
        chk("t3_rel_err", a_err, 0);
        chk("t3_held0_rel", held[0], 0);
        drv_a(0, RD, 0, 0); drv_b(1, RD, 0, 0);
        step;
        chk("t3_b_done", b_done, 1);
        chk("t3_b_err", b_err, 0);
        chk("t3_b_rdata", b_rdata, 0);
        drv_b(0, RD, 0, 0);

        // async reset clears held state immediately
        reset = 1'b1; #1;
        chk("rst2_held", held, 0);
        step;
        reset = 1'b0;

        // write/write conflict with round-robin
        drv_a(1, WR, 3, 8'hFF); drv_b(1, WR, 3, 8'h11); #1;
        chk("t4_a_ready", a_ready, 1);
        chk("t4_b_ready", b_ready, 0);
        step;
        chk("t4_a_done", a_done, 1);
        chk("t4_b_stall", b_done, 0);
        drv_a(0, RD, 0, 0);
        step;
        chk("t4_b_done", b_done, 1);
        chk("t4_a_idle", a_done, 0);
        drv_b(0, RD, 0, 0); drv_a(1, RD, 3, 0);
        step;
        chk("t4_mem3", a_rdata, 8'h11);
        drv_a(1, WR, 3, 8'hFF); drv_b(1, WR, 3, 8'h11); #1;
        chk("t4r_a_ready", a_ready, 0);
        chk("t4r_b_ready", b_ready, 1);
        step;
        chk("t4r_b_done", b_done, 1);
        chk("t4r_a_stall", a_done, 0);
        drv_b(0, RD, 0, 0);
        step;
        chk("t4r_a_done", a_done, 1);
        drv_a(0, RD, 0, 0); drv_b(1, RD, 3, 0);
        step;
        chk("t4r_mem3", b_rdata, 8'hFF);
        drv_b(0, RD, 0, 0);

        // shared read, then release of a free address
        drv_a(1, WR, 1, 8'h3C);
        step;
        drv_a(1, RD, 1, 0); drv_b(1, RD, 1, 0); #1;
        chk("t5_a_ready", a_ready, 1);
        chk("t5_b_ready", b_ready, 1);
        step;
        chk("t5_a_done", a_done, 1);
        chk("t5_b_done", b_done, 1);
        chk("t5_a_rdata", a_rdata, 8'h3C);
        chk("t5_b_rdata", b_rdata, 8'h3C);
        drv_a(0, RD, 0, 0); drv_b(1, RL, 1, 0);
        step;
        chk("t5_rel_done", b_done, 1);
        chk("t5_rel_free_err", b_err, 1);

        // ownership enforcement against the non-owner
        drv_b(1, HD, 1, 0);
        step;
        chk("own_b_hold_err", b_err, 0);
        chk("own_held1", held[1], 1);
        chk("own_owner1", owner_b[1], 1);
        drv_b(0, RD, 0, 0); drv_a(1, WR, 1, 8'h77);
        step;
        chk("own_a_wr_err", a_err, 1);
        drv_a(1, RL, 1, 0);
        step;
        chk("own_a_rel_err", a_err, 1);
        drv_a(1, HD, 1, 0);
        step;
        chk("own_a_hold_err", a_err, 1);
        chk("own_owner1_kept", owner_b[1], 1);
        drv_a(0, RD, 0, 0); drv_b(1, HD, 1, 0);
        step;
        chk("own_b_rehold_err", b_err, 0);
        drv_b(1, WR, 1, 8'h55);
        step;
        chk("own_b_wr_err", b_err, 0);
        drv_b(1, RL, 1, 0);
        step;
        chk("own_b_rel_err", b_err, 0);
        chk("own_held1_rel", held[1], 0);
        drv_b(0, RD, 0, 0); drv_a(1, RD, 1, 0);
        step;
        chk("own_mem1", a_rdata, 8'h55);
        chk("own_rd_err", a_err, 0);

        // reset mid-transaction drops the request
        drv_a(1, WR, 0, 8'h99); #1;
        reset = 1'b1; #1;
        chk("mid_rst_done", a_done, 0);
        chk("mid_rst_rdata", a_rdata, 0);
        step;
        drv_a(0, RD, 0, 0);
        reset = 1'b0;
        step;
        drv_a(1, RD, 0, 0);
        step;
        chk("mid_rst_mem0", a_rdata, 0);
        drv_a(0, RD, 0, 0);

`ifdef CSM_HOLD_TIMEOUT_EN
        drv_b(1, HD, 2, 0);
        step;
        chk("to_held2", held[2], 1);
        chk("to_exp_early", hold_expired, 0);
        drv_b(0, RD, 0, 0);
        step; step; step;
        chk("to_held2_3", held[2], 1);
        chk("to_exp_3", hold_expired, 0);
        step;
        chk("to_exp_4", hold_expired, 4'b0100);
        chk("to_held2_4", held[2], 0);
        step;
        chk("to_exp_pulse_end", hold_expired, 0);
        drv_b(1, HD, 2, 0);
        step;
        drv_b(0, RD, 0, 0);
        step;
        reset = 1'b1; #1;
        chk("to_rst_held", held, 0);
        step;
        reset = 1'b0;
`else
        drv_b(1, HD, 2, 0);
        step;
        drv_b(0, RD, 0, 0);
        repeat (20) step;
        chk("persist_held2", held[2], 1);
        chk("persist_owner2", owner_b[2], 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
